// File: rtl/mppt_pkg.sv
// Shared encodings and default widths for the perturb-and-observe MPPT core.
// Imported by the controller top and by its duty-step helper.
package mppt_pkg;

  localparam int unsigned W_ADC_DEF     = 10;
  localparam int unsigned W_DUTY_DEF    = 10;
  localparam int unsigned STEP_DEF      = 4;
  localparam int unsigned DUTY_MIN_DEF  = 50;
  localparam int unsigned DUTY_MAX_DEF  = 950;
  localparam int unsigned DUTY_INIT_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POWER   = 3'd1,
    ST_COMPARE = 3'd2,
    ST_PERTURB = 3'd3
  } mppt_state_e;

  localparam logic [1:0] FLAG_EQ    = 2'b00;
  localparam logic [1:0] FLAG_UP    = 2'b01;
  localparam logic [1:0] FLAG_DN    = 2'b10;
  localparam logic [1:0] FLAG_NOREF = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Power comparison result as a flag; a missing reference overrides everything.
  function automatic logic [1:0] power_flag(input logic ref_ok,
                                            input logic [31:0] p_now,
                                            input logic [31:0] p_old);
    logic [1:0] f;
    if (!ref_ok) begin
      f = FLAG_NOREF;
    end else if (p_now > p_old) begin
      f = FLAG_UP;
    end else if (p_now < p_old) begin
      f = FLAG_DN;
    end else begin
      f = FLAG_EQ;
    end
    return f;
  endfunction

endpackage

// File: rtl/mppt_duty_step.sv
// Combinational duty perturbation: step in the current direction, clamp to the
// allowed window and reverse direction whenever a clamp is reached.
module mppt_duty_step
  import mppt_pkg::*;
#(
  parameter int unsigned W_DUTY   = W_DUTY_DEF,
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned DUTY_MIN = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic [W_DUTY-1:0] duty,
  input  logic              dir,
  input  logic [1:0]        flag,
  output logic [W_DUTY-1:0] duty_next,
  output logic              dir_next
);

  localparam logic [W_DUTY:0]   STEP_W  = (W_DUTY+1)'(STEP);
  localparam logic [W_DUTY:0]   MIN_W   = (W_DUTY+1)'(DUTY_MIN);
  localparam logic [W_DUTY:0]   MAX_W   = (W_DUTY+1)'(DUTY_MAX);
  localparam logic [W_DUTY-1:0] MIN_N   = W_DUTY'(DUTY_MIN);
  localparam logic [W_DUTY-1:0] MAX_N   = W_DUTY'(DUTY_MAX);

  logic [W_DUTY:0] duty_wide_s;
  logic [W_DUTY:0] cand_s;

  // One-bit-wider step; on the way down the extra bit flags a wrap below zero.
  always_comb begin
    duty_wide_s = {1'b0, duty};
    cand_s      = duty_wide_s;
    duty_next   = duty;
    dir_next    = dir;
    if (flag == FLAG_EQ) begin
      duty_next = duty;
      dir_next  = dir;
    end else if (dir == DIR_UP) begin
      cand_s = duty_wide_s + STEP_W;
      if (cand_s >= MAX_W) begin
        duty_next = MAX_N;
        dir_next  = DIR_DN;
      end else begin
        duty_next = cand_s[W_DUTY-1:0];
        dir_next  = dir;
      end
    end else begin
      cand_s = duty_wide_s - STEP_W;
      if (cand_s[W_DUTY] || (cand_s <= MIN_W)) begin
        duty_next = MIN_N;
        dir_next  = DIR_UP;
      end else begin
        duty_next = cand_s[W_DUTY-1:0];
        dir_next  = dir;
      end
    end
  end

endmodule

// File: rtl/mppt_po_controlador.sv
// Perturb-and-observe MPPT control core: one sample per four cycles, forms
// v*i, compares with the previous power and steps the duty command.
module mppt_po_controlador
  import mppt_pkg::*;
#(
  parameter int unsigned W_ADC     = W_ADC_DEF,
  parameter int unsigned W_DUTY    = W_DUTY_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned DUTY_MIN  = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX  = DUTY_MAX_DEF,
  parameter int unsigned DUTY_INIT = DUTY_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [W_ADC-1:0]  v_in,
  input  logic [W_ADC-1:0]  i_in,
  output logic              busy,
  output logic [W_DUTY-1:0] duty,
  output logic              duty_valid,
  output logic [2:0]        state,
  output logic [1:0]        flag
);

  localparam int unsigned    W_P       = 2 * W_ADC;
  localparam logic [W_DUTY-1:0] DUTY_RST = W_DUTY'(DUTY_INIT);

  mppt_state_e       state_r;
  logic [W_ADC-1:0]  v_r;
  logic [W_ADC-1:0]  i_r;
  logic [W_P-1:0]    p_r;
  logic [W_P-1:0]    p_prev_r;
  logic              p_prev_ok_r;
  logic [1:0]        flag_r;
  logic              dir_r;
  logic [W_DUTY-1:0] duty_r;
  logic              duty_valid_r;
  logic [W_DUTY-1:0] duty_next_s;
  logic              dir_next_s;

  mppt_duty_step #(
    .W_DUTY   (W_DUTY),
    .STEP     (STEP),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX)
  ) u_duty_step (
    .duty      (duty_r),
    .dir       (dir_r),
    .flag      (flag_r),
    .duty_next (duty_next_s),
    .dir_next  (dir_next_s)
  );

  // Sample / power / compare / perturb sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      v_r          <= {W_ADC{1'b0}};
      i_r          <= {W_ADC{1'b0}};
      p_r          <= {W_P{1'b0}};
      p_prev_r     <= {W_P{1'b0}};
      p_prev_ok_r  <= 1'b0;
      flag_r       <= FLAG_EQ;
      dir_r        <= DIR_UP;
      duty_r       <= DUTY_RST;
      duty_valid_r <= 1'b0;
    end else begin
      duty_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sample_valid) begin
            v_r     <= v_in;
            i_r     <= i_in;
            state_r <= ST_POWER;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_POWER: begin
          p_r     <= W_P'(v_r) * W_P'(i_r);
          state_r <= ST_COMPARE;
        end
        ST_COMPARE: begin
          flag_r <= power_flag(p_prev_ok_r, 32'(p_r), 32'(p_prev_r));
          // Falling power means the last perturbation went the wrong way.
          if (p_prev_ok_r && (p_r < p_prev_r)) begin
            dir_r <= ~dir_r;
          end else begin
            dir_r <= dir_r;
          end
          p_prev_r    <= p_r;
          p_prev_ok_r <= 1'b1;
          state_r     <= ST_PERTURB;
        end
        ST_PERTURB: begin
          duty_r       <= duty_next_s;
          dir_r        <= dir_next_s;
          duty_valid_r <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign state      = state_r;
  assign busy       = (state_r != ST_IDLE);
  assign flag       = flag_r;
  assign duty       = duty_r;
  assign duty_valid = duty_valid_r;

endmodule
